// File: rtl/dcache_line_adapter.sv
// Line-to-burst adapter: moves one cache line between the dcache and a
// beat-wide memory bus as an ascending, fixed-length burst.
// Optional feature macro: DCACHE_LINE_ADAPTER_PERF_EN enables the completed-burst
// counters on perf_reads_o / perf_writes_o; otherwise both ports are tied to 0.
module dcache_line_adapter #(
  parameter int unsigned SLine = 256,
  parameter int unsigned SBeat = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pmem_read_i,
  input  logic             pmem_write_i,
  input  logic [31:0]      pmem_address_i,
  input  logic [SLine-1:0] pmem_wdata_i,
  output logic [SLine-1:0] pmem_rdata_o,
  output logic             mem_resp_o,
  output logic             burst_read_o,
  output logic             burst_write_o,
  output logic [31:0]      burst_address_o,
  output logic [SBeat-1:0] burst_wdata_o,
  input  logic [SBeat-1:0] burst_rdata_i,
  input  logic             burst_resp_i,
  output logic [31:0]      perf_reads_o,
  output logic [31:0]      perf_writes_o
);

  localparam int unsigned NumBeats = SLine / SBeat;
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam int unsigned OffW     = $clog2(SLine / 8);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [SLine-1:0]  wdata_q, wdata_d;
  logic [SLine-1:0]  rdata_q, rdata_d;
  logic              last_beat;
  logic              unused_addr;

  // Line offset bits never reach the memory bus.
  assign unused_addr = ^pmem_address_i[OffW-1:0];
  assign last_beat   = (cnt_q == CntW'(NumBeats - 1));

  // State, beat counter and latched request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: accept in idle (write has priority), count accepted beats, pulse done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (pmem_write_i) begin
          state_d = StWrite;
          cnt_d   = '0;
          addr_d  = {pmem_address_i[31:OffW], OffW'(0)};
          wdata_d = pmem_wdata_i;
        end else if (pmem_read_i) begin
          state_d = StRead;
          cnt_d   = '0;
          addr_d  = {pmem_address_i[31:OffW], OffW'(0)};
        end
      end
      StRead: begin
        if (burst_resp_i) begin
          for (int unsigned k = 0; k < NumBeats; k++) begin
            if (cnt_q == CntW'(k)) rdata_d[k*SBeat +: SBeat] = burst_rdata_i;
          end
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) state_d = StDone;
        end
      end
      StWrite: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Current write beat selected by the counter.
  always_comb begin
    burst_wdata_o = '0;
    for (int unsigned k = 0; k < NumBeats; k++) begin
      if (cnt_q == CntW'(k)) burst_wdata_o = wdata_q[k*SBeat +: SBeat];
    end
  end

  assign burst_read_o    = (state_q == StRead);
  assign burst_write_o   = (state_q == StWrite);
  assign mem_resp_o      = (state_q == StDone);
  assign burst_address_o = addr_q;
  assign pmem_rdata_o    = rdata_q;

`ifdef DCACHE_LINE_ADAPTER_PERF_EN
  logic        op_write_q;
  logic [31:0] perf_reads_q, perf_writes_q;

  // Remember the burst direction and count each completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_write_q    <= 1'b0;
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
    end else begin
      if (state_q == StIdle && (pmem_write_i || pmem_read_i)) op_write_q <= pmem_write_i;
      if (state_q == StDone) begin
        if (op_write_q) perf_writes_q <= perf_writes_q + 32'd1;
        else            perf_reads_q  <= perf_reads_q + 32'd1;
      end
    end
  end

  assign perf_reads_o  = perf_reads_q;
  assign perf_writes_o = perf_writes_q;
`else
  assign perf_reads_o  = '0;
  assign perf_writes_o = '0;
`endif

endmodule

// File: tb/tb_dcache_line_adapter.sv
// Self-checking bench for dcache_line_adapter: directed vector table, hand-written
// reset sequence and randomized transactions against a line-level reference model.
module tb_dcache_line_adapter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         pmem_read_i, pmem_write_i;
  logic [31:0]  pmem_address_i;
  logic [255:0] pmem_wdata_i;
  logic [255:0] pmem_rdata_o;
  logic         mem_resp_o, burst_read_o, burst_write_o;
  logic [31:0]  burst_address_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;
  logic [31:0]  perf_reads_o, perf_writes_o;

  dcache_line_adapter dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .pmem_read_i     (pmem_read_i),
    .pmem_write_i    (pmem_write_i),
    .pmem_address_i  (pmem_address_i),
    .pmem_wdata_i    (pmem_wdata_i),
    .pmem_rdata_o    (pmem_rdata_o),
    .mem_resp_o      (mem_resp_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_address_o (burst_address_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i),
    .perf_reads_o    (perf_reads_o),
    .perf_writes_o   (perf_writes_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    int           mode;      // 0 zero-wait, 1 toggling, 2 random
    bit           drop;      // cache drops request mid-burst
    logic [31:0]  exp_addr;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           nreads = 0;
  int           nwrites = 0;
  logic [255:0] last_rline = '0;   // model of the held fill line
  vec_t         vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One line transaction; the model knows only the line, the beat order and the
  // rule that completion follows the fourth accepted beat by one cycle.
  task automatic run_txn(input vec_t v);
    bit is_wr;
    bit resp;
    int k;
    int cyc;
    is_wr = v.wr;
    k = 0;
    cyc = 0;
    pmem_read_i    = v.rd;
    pmem_write_i   = v.wr;
    pmem_address_i = v.addr;
    pmem_wdata_i   = v.wline;
    burst_resp_i   = 1'b0;
    @(negedge clk_i);
    chk("req_cycle_quiet", {burst_read_o, burst_write_o, mem_resp_o}, 0);
    @(posedge clk_i); #1;
    // Changes after acceptance must be ignored.
    pmem_address_i = $urandom;
    pmem_wdata_i   = rnd_line();
    while (k < 4 && cyc < 200) begin
      case (v.mode)
        0:       resp = 1'b1;
        1:       resp = (cyc % 2) == 1;
        default: resp = 1'($urandom_range(0, 1));
      endcase
      if (v.drop && cyc == 1) begin
        pmem_read_i  = 1'b0;
        pmem_write_i = 1'b0;
      end
      burst_resp_i  = resp;
      burst_rdata_i = resp ? v.rline[64*k +: 64] : {$urandom, $urandom};
      @(negedge clk_i);
      chk("burst_read", burst_read_o, !is_wr);
      chk("burst_write", burst_write_o, is_wr);
      chk("burst_address", burst_address_o, v.exp_addr);
      chk("resp_early", mem_resp_o, 0);
      if (is_wr) chk("burst_wdata", burst_wdata_o, v.wline[64*k +: 64]);
      if (resp) k++;
      cyc++;
      @(posedge clk_i); #1;
    end
    if (k < 4) chk("burst_timeout", k, 4);
    if (!is_wr) last_rline = v.rline;
    // Done cycle: stray beats on the bus must be ignored.
    burst_resp_i  = 1'b1;
    burst_rdata_i = {$urandom, $urandom};
    @(negedge clk_i);
    chk("mem_resp", mem_resp_o, 1);
    chk("done_no_burst", {burst_read_o, burst_write_o}, 0);
    chk("rdata_done", pmem_rdata_o, last_rline);
    @(posedge clk_i); #1;
    pmem_read_i  = 1'b0;
    pmem_write_i = 1'b0;
    @(negedge clk_i);
    chk("resp_single", mem_resp_o, 0);
    chk("idle_no_burst", {burst_read_o, burst_write_o}, 0);
    chk("rdata_hold", pmem_rdata_o, last_rline);
    @(posedge clk_i); #1;
    burst_resp_i = 1'b0;
    @(negedge clk_i);
    chk("no_reissue", {burst_read_o, burst_write_o, mem_resp_o}, 0);
    @(posedge clk_i); #1;
    if (is_wr) nwrites++;
    else       nreads++;
  endtask

  task automatic chk_perf(input string tag);
`ifdef DCACHE_LINE_ADAPTER_PERF_EN
    chk({tag, "_perf_reads"}, perf_reads_o, nreads);
    chk({tag, "_perf_writes"}, perf_writes_o, nwrites);
`else
    chk({tag, "_perf_reads"}, perf_reads_o, 0);
    chk({tag, "_perf_writes"}, perf_writes_o, 0);
`endif
  endtask

  initial begin
    vec_t v;
    logic [255:0] lw;

    vecs[0] = '{wr: 0, rd: 1, addr: 32'h0000_1234, wline: '0,
                rline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                mode: 0, drop: 0, exp_addr: 32'h0000_1220};
    vecs[1] = '{wr: 1, rd: 0, addr: 32'h8000_001F,
                wline: {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                        64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
                rline: '0, mode: 1, drop: 0, exp_addr: 32'h8000_0000};
    vecs[2] = '{wr: 1, rd: 1, addr: 32'hFFFF_FFFF, wline: rnd_line(), rline: '0,
                mode: 2, drop: 0, exp_addr: 32'hFFFF_FFE0};
    vecs[3] = '{wr: 0, rd: 1, addr: 32'h0000_0040, wline: '0, rline: rnd_line(),
                mode: 2, drop: 1, exp_addr: 32'h0000_0040};
    vecs[4] = '{wr: 1, rd: 0, addr: 32'hDEAD_BEEF, wline: rnd_line(), rline: '0,
                mode: 0, drop: 1, exp_addr: 32'hDEAD_BEE0};

    rst_ni         = 1'b0;
    pmem_read_i    = 1'b0;
    pmem_write_i   = 1'b0;
    pmem_address_i = '0;
    pmem_wdata_i   = '0;
    burst_rdata_i  = '0;
    burst_resp_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_outputs", {burst_read_o, burst_write_o, mem_resp_o}, 0);
    chk("rst_address", burst_address_o, 0);
    chk("rst_rdata", pmem_rdata_o, 0);
    chk("rst_wdata", burst_wdata_o, 0);
    chk_perf("rst");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed vectors, then back-to-back write followed by read.
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
    run_txn(vecs[1]);
    run_txn(vecs[0]);
    chk_perf("directed");

    // Reset during beat 2 of a zero-wait read.
    lw = rnd_line();
    pmem_read_i    = 1'b1;
    pmem_address_i = 32'h0001_0000;
    @(posedge clk_i); #1;
    for (int b = 0; b < 2; b++) begin
      burst_resp_i  = 1'b1;
      burst_rdata_i = lw[64*b +: 64];
      @(posedge clk_i); #1;
    end
    burst_resp_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_burst_read", burst_read_o, 0);
    chk("midrst_resp", mem_resp_o, 0);
    chk("midrst_address", burst_address_o, 0);
    chk("midrst_rdata", pmem_rdata_o, 0);
    pmem_read_i  = 1'b0;
    burst_resp_i = 1'b0;
    nreads     = 0;
    nwrites    = 0;
    last_rline = '0;
    chk_perf("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    v = vecs[0];
    v.rline = rnd_line();
    run_txn(v);

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      v.wr       = 1'($urandom_range(0, 1));
      v.rd       = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr     = $urandom;
      v.exp_addr = v.addr & 32'hFFFF_FFE0;
      v.wline    = rnd_line();
      v.rline    = rnd_line();
      v.mode     = 2;
      v.drop     = 1'($urandom_range(0, 1));
      run_txn(v);
    end
    chk_perf("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
